cordic_ctrl_seq: RTL and testbench

//  Parametrised control FSM for the iterative CORDIC datapath. Owns the iteration counter,

---
 rtl/cordic_ctrl_seq.sv | 103 ++++++++++
 tb/tb_cordic_ctrl_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_ctrl_seq.sv
// Control sequencer for an iterative CORDIC datapath. It owns the iteration counter
// and per-run mode, and drives the load strobes and the micro-rotation direction.
module cordic_ctrl_seq #(
  parameter int unsigned ITER_W    = 4,
  parameter bit          FIN_PULSE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              bgn,
  input  logic              mode_in,
  input  logic [ITER_W-1:0] iter_max,
  input  logic              abort,
  input  logic              ack,
  input  logic              z_neg,
  input  logic              y_neg,
  output logic              rdy,
  output logic              busy,
  output logic              init,
  output logic              ld,
  output logic [ITER_W-1:0] itr,
  output logic              rot_neg,
  output logic              mode_o,
  output logic              fin
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [ITER_W-1:0] itr_q,      itr_d;
  logic [ITER_W-1:0] iter_max_q, iter_max_d;
  logic              mode_q,     mode_d;
  logic              accept;

  assign accept = (state_q == S_IDLE) && bgn && !abort;

  always_comb begin
    state_d    = state_q;
    itr_d      = itr_q;
    iter_max_d = iter_max_q;
    mode_d     = mode_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d     = mode_in;
          iter_max_d = iter_max;
          itr_d      = '0;
          state_d    = S_ITER;
        end
      end
      S_ITER: begin
        // Abort outranks completion, so a last-iteration abort never reaches DONE.
        if (abort) begin
          state_d = S_IDLE;
          itr_d   = '0;
        end else if (itr_q == iter_max_q) begin
          state_d = S_DONE;
          itr_d   = '0;
        end else begin
          itr_d = itr_q + 1'b1;
        end
      end
      S_DONE: begin
        itr_d = '0;
        if (abort || FIN_PULSE || ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        itr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      itr_q      <= '0;
      iter_max_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      itr_q      <= itr_d;
      iter_max_q <= iter_max_d;
      mode_q     <= mode_d;
    end
  end

  always_comb begin
    rdy     = (state_q == S_IDLE);
    busy    = (state_q == S_ITER);
    fin     = (state_q == S_DONE);
    init    = accept;
    ld      = accept || busy;
    itr     = itr_q;
    mode_o  = mode_q;
    // Rotation drives z toward zero, vectoring drives y toward zero.
    rot_neg = busy && (mode_q ? !y_neg : z_neg);
  end

endmodule

// File: tb/tb_cordic_ctrl_seq.sv
// Bench for cordic_ctrl_seq: directed cycle checks plus a run scoreboard holding the
// expected iteration count, mode and completion of every started run.
module tb_cordic_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       bgn_p = 1'b0, bgn_h = 1'b0;
  logic       mode_in = 1'b0;
  logic [3:0] iter_max = '0;
  logic       abort = 1'b0, ack = 1'b0, z_neg = 1'b0, y_neg = 1'b0;

  logic       rdy_p, busy_p, init_p, ld_p, rot_neg_p, mode_o_p, fin_p;
  logic [3:0] itr_p;
  logic       rdy_h, busy_h, init_h, ld_h, rot_neg_h, mode_o_h, fin_h;
  logic [3:0] itr_h;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic        mode;
    int unsigned cnt;
    logic        fin;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cordic_ctrl_seq #(.ITER_W(4), .FIN_PULSE(1'b1)) u_p (
    .clk(clk), .rst_b(rst_b), .bgn(bgn_p), .mode_in(mode_in), .iter_max(iter_max),
    .abort(abort), .ack(ack), .z_neg(z_neg), .y_neg(y_neg),
    .rdy(rdy_p), .busy(busy_p), .init(init_p), .ld(ld_p), .itr(itr_p),
    .rot_neg(rot_neg_p), .mode_o(mode_o_p), .fin(fin_p));

  cordic_ctrl_seq #(.ITER_W(4), .FIN_PULSE(1'b0)) u_h (
    .clk(clk), .rst_b(rst_b), .bgn(bgn_h), .mode_in(mode_in), .iter_max(iter_max),
    .abort(abort), .ack(ack), .z_neg(z_neg), .y_neg(y_neg),
    .rdy(rdy_h), .busy(busy_h), .init(init_h), .ld(ld_h), .itr(itr_h),
    .rot_neg(rot_neg_h), .mode_o(mode_o_h), .fin(fin_h));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic m, input int unsigned n, input logic f);
    exp_t e;
    e.mode = m;
    e.cnt  = n;
    e.fin  = f;
    sb.push_back(e);
  endtask

  // Run monitor on the pulse-mode instance: itr must count up from 0 while busy,
  // and the run's length/mode/completion are compared when rdy returns.
  int unsigned mon_cnt = 0;
  logic        mon_in_run = 1'b0, mon_fin = 1'b0, mon_mode = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy_p) begin
      check_eq("mon_itr", {28'd0, itr_p}, mon_cnt);
      mon_cnt++;
      mon_mode = mode_o_p;
      mon_in_run = 1'b1;
    end
    if (fin_p) mon_fin = 1'b1;
    if (rdy_p && mon_in_run) begin
      check_eq("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("sb_count", mon_cnt, e.cnt);
        check_eq("sb_mode", {31'd0, mon_mode}, {31'd0, e.mode});
        check_eq("sb_fin", {31'd0, mon_fin}, {31'd0, e.fin});
      end
      mon_cnt = 0;
      mon_fin = 1'b0;
      mon_in_run = 1'b0;
    end
  end

  initial begin
    // Reset state
    #2;
    check_eq("rst_rdy", {31'd0, rdy_p}, 1);
    check_eq("rst_busy", {31'd0, busy_p}, 0);
    check_eq("rst_fin", {31'd0, fin_p}, 0);
    check_eq("rst_itr", {28'd0, itr_p}, 0);
    check_eq("rst_mode", {31'd0, mode_o_p}, 0);
    check_eq("rst_rot", {31'd0, rot_neg_p}, 0);
    check_eq("rst_ld", {31'd0, ld_p}, 0);
    check_eq("rst_init", {31'd0, init_p}, 0);
    tick();
    rst_b = 1'b1;
    tick();

    // 1: rotation, 16 iterations, pulse completion
    bgn_p = 1'b1; mode_in = 1'b0; iter_max = 4'd15;
    push(1'b0, 16, 1'b1);
    smp();
    check_eq("t1_init0", {31'd0, init_p}, 1);
    check_eq("t1_ld0", {31'd0, ld_p}, 1);
    check_eq("t1_rdy0", {31'd0, rdy_p}, 1);
    for (int c = 1; c <= 16; c++) begin
      tick();
      bgn_p = 1'b0;
      z_neg = c[0];
      smp();
      check_eq("t1_busy", {31'd0, busy_p}, 1);
      check_eq("t1_itr", {28'd0, itr_p}, c - 1);
      check_eq("t1_ld", {31'd0, ld_p}, 1);
      check_eq("t1_init", {31'd0, init_p}, 0);
      check_eq("t1_rot", {31'd0, rot_neg_p}, {31'd0, z_neg});
    end
    tick(); smp();
    check_eq("t1_fin", {31'd0, fin_p}, 1);
    check_eq("t1_ld_done", {31'd0, ld_p}, 0);
    check_eq("t1_rdy_done", {31'd0, rdy_p}, 0);
    check_eq("t1_rot_done", {31'd0, rot_neg_p}, 0);
    tick(); smp();
    check_eq("t1_rdy18", {31'd0, rdy_p}, 1);
    check_eq("t1_fin18", {31'd0, fin_p}, 0);

    // 2: vectoring, direction follows ~y_neg, z_neg ignored
    tick();
    bgn_p = 1'b1; mode_in = 1'b1; iter_max = 4'd3;
    push(1'b1, 4, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      bgn_p = 1'b0;
      y_neg = c[1];
      z_neg = ~z_neg;
      smp();
      check_eq("t2_rot", {31'd0, rot_neg_p}, {31'd0, ~y_neg});
      check_eq("t2_mode", {31'd0, mode_o_p}, 1);
    end
    tick(); y_neg = 1'b0; smp();
    check_eq("t2_fin", {31'd0, fin_p}, 1);
    check_eq("t2_rot_done", {31'd0, rot_neg_p}, 0);
    tick(); smp();
    check_eq("t2_rot_idle", {31'd0, rot_neg_p}, 0);
    check_eq("t2_rdy", {31'd0, rdy_p}, 1);

    // 3: held completion on the ack-mode instance
    tick();
    bgn_h = 1'b1; mode_in = 1'b0; iter_max = 4'd7;
    smp();
    check_eq("t3_init0", {31'd0, init_h}, 1);
    check_eq("t3_ld0", {31'd0, ld_h}, 1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      bgn_h = 1'b0;
      z_neg = c[0];
      smp();
      check_eq("t3_busy", {31'd0, busy_h}, 1);
      check_eq("t3_itr", {28'd0, itr_h}, c - 1);
      check_eq("t3_rot", {31'd0, rot_neg_h}, {31'd0, z_neg});
    end
    for (int c = 9; c <= 14; c++) begin
      tick();
      bgn_h = (c == 12) || (c == 14);
      ack = (c == 14);
      smp();
      check_eq("t3_fin_held", {31'd0, fin_h}, 1);
      check_eq("t3_rdy_held", {31'd0, rdy_h}, 0);
      check_eq("t3_init_held", {31'd0, init_h}, 0);
      check_eq("t3_ld_held", {31'd0, ld_h}, 0);
    end
    tick(); ack = 1'b0; bgn_h = 1'b0; smp();
    check_eq("t3_rdy15", {31'd0, rdy_h}, 1);
    check_eq("t3_fin15", {31'd0, fin_h}, 0);
    check_eq("t3_mode15", {31'd0, mode_o_h}, 0);
    check_eq("t3_p_idle", {31'd0, rdy_p}, 1);
    tick(); smp();
    check_eq("t3_no_accept", {31'd0, busy_h}, 0);

    // 4: abort at itr=7, then bgn+abort in IDLE
    tick();
    bgn_p = 1'b1; mode_in = 1'b0; iter_max = 4'd15;
    push(1'b0, 8, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      bgn_p = 1'b0;
      abort = (c == 8);
      smp();
    end
    check_eq("t4_itr7", {28'd0, itr_p}, 7);
    for (int c = 9; c <= 11; c++) begin
      tick();
      abort = 1'b0;
      smp();
      check_eq("t4_rdy", {31'd0, rdy_p}, 1);
      check_eq("t4_itr", {28'd0, itr_p}, 0);
      check_eq("t4_fin", {31'd0, fin_p}, 0);
    end
    tick();
    bgn_p = 1'b1; abort = 1'b1;
    smp();
    check_eq("t4_blk_init", {31'd0, init_p}, 0);
    check_eq("t4_blk_ld", {31'd0, ld_p}, 0);
    tick();
    bgn_p = 1'b0; abort = 1'b0;
    smp();
    check_eq("t4_blk_idle", {31'd0, rdy_p}, 1);

    // 5: single-iteration run, then iter_max changed mid-run
    tick();
    bgn_p = 1'b1; mode_in = 1'b0; iter_max = 4'd0;
    push(1'b0, 1, 1'b1);
    tick(); bgn_p = 1'b0; smp();
    check_eq("t5_busy1", {31'd0, busy_p}, 1);
    tick(); smp();
    check_eq("t5_fin2", {31'd0, fin_p}, 1);
    tick(); smp();
    check_eq("t5_rdy3", {31'd0, rdy_p}, 1);
    tick();
    bgn_p = 1'b1; mode_in = 1'b1; iter_max = 4'd15;
    push(1'b1, 16, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      tick();
      bgn_p = 1'b0;
      iter_max = 4'd2;
      smp();
      check_eq("t5_busy", {31'd0, busy_p}, 1);
    end
    tick(); smp();
    check_eq("t5_fin17", {31'd0, fin_p}, 1);

    // 6: asynchronous reset mid-run, then a clean run
    tick(); tick();
    bgn_p = 1'b1; mode_in = 1'b0; iter_max = 4'd15;
    push(1'b0, 6, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      bgn_p = 1'b0;
      smp();
    end
    check_eq("t6_itr5", {28'd0, itr_p}, 5);
    #1 rst_b = 1'b0;
    #1;
    check_eq("t6_rdy", {31'd0, rdy_p}, 1);
    check_eq("t6_busy", {31'd0, busy_p}, 0);
    check_eq("t6_itr", {28'd0, itr_p}, 0);
    check_eq("t6_fin", {31'd0, fin_p}, 0);
    tick(); tick();
    rst_b = 1'b1;
    tick();
    bgn_p = 1'b1; iter_max = 4'd2;
    push(1'b0, 3, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      bgn_p = 1'b0;
      smp();
      check_eq("t6_run_itr", {28'd0, itr_p}, c - 1);
    end
    tick(); smp();
    check_eq("t6_run_fin", {31'd0, fin_p}, 1);

    repeat (3) tick();
    check_eq("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
